// File: rtl/clock_pkg.sv
// clock_pkg: shared limits and mode encodings for the time-of-day counter
package clock_pkg;
    localparam logic [4:0] MAX_HR  = 5'd23;
    localparam logic [5:0] MAX_MIN = 6'd59;
    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [2:0] MODE_RUN     = 3'd0;
    localparam logic [2:0] MODE_SET_SEC = 3'd1;
    localparam logic [2:0] MODE_SET_MIN = 3'd2;
    localparam logic [2:0] MODE_SET_HR  = 3'd3;
endpackage

// File: rtl/clock_display_decoder.sv
// display_decoder: splits a 0-59 binary value into decimal tens/ones digits
//   value in 6b binary; tens, ones out 6b digits (bits [5:4] always 0)
module display_decoder (
    input  logic [5:0] value,
    output logic [5:0] tens,
    output logic [5:0] ones
);
    assign tens = value / 6'd10;
    assign ones = value % 6'd10;
endmodule

// File: rtl/clock.sv
// clock: 24-hour hh:mm:ss counter with per-second prescaler, preset load and digit decode
//   clk, rst (async, active-high); switch run enable; mode 0 run, 1-3 set, 4-7 freeze
//   hours/minutes/seconds presets (clamped); six 6b decimal digit outputs
module clock
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch,
    input  logic [2:0] mode,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [5:0] hrstens,
    output logic [5:0] hrsones,
    output logic [5:0] mintens,
    output logic [5:0] minones,
    output logic [5:0] sectens,
    output logic [5:0] secones
);
    // at least one bit so TICK_DIV = 1 still elaborates
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [4:0]    hr_q;
    logic [5:0]    min_q, sec_q;
    logic [PW-1:0] pre_q;
    logic          set, run, tick, sec_wrap, min_wrap;
    logic [4:0]    hr_set;
    logic [5:0]    min_set, sec_set;
    assign set      = mode inside {MODE_SET_SEC, MODE_SET_MIN, MODE_SET_HR};
    assign run      = mode == MODE_RUN && switch;
    assign tick     = pre_q == PW'(TICK_DIV - 1);
    assign sec_wrap = sec_q == MAX_SEC;
    assign min_wrap = min_q == MAX_MIN;
    assign hr_set   = hours > MAX_HR ? MAX_HR : hours;
    assign min_set  = minutes > MAX_MIN ? MAX_MIN : minutes;
    assign sec_set  = seconds > MAX_SEC ? MAX_SEC : seconds;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_q  <= '0;
            min_q <= '0;
            sec_q <= '0;
            pre_q <= '0;
        end else if (set) begin
            hr_q  <= hr_set;
            min_q <= min_set;
            sec_q <= sec_set;
            pre_q <= '0;
        end else if (run) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                sec_q <= sec_wrap ? '0 : sec_q + 6'd1;
                if (sec_wrap)
                    min_q <= min_wrap ? '0 : min_q + 6'd1;
                if (sec_wrap && min_wrap)
                    hr_q <= hr_q == MAX_HR ? '0 : hr_q + 5'd1;
            end
        end
    end
    display_decoder u_hr (.value({1'b0, hr_q}), .tens(hrstens), .ones(hrsones));
    display_decoder u_min (.value(min_q), .tens(mintens), .ones(minones));
    display_decoder u_sec (.value(sec_q), .tens(sectens), .ones(secones));
endmodule

// File: tb/tb_clock.sv
// tb_clock: vector table, reset sequence and randomized run against a seconds-of-day model
module tb_clock;
    localparam int TD = 4;
    logic       clk = 0, rst = 1, switch = 0;
    logic [2:0] mode = 0;
    logic [4:0] hours = 0;
    logic [5:0] minutes = 0, seconds = 0;
    logic [5:0] hrstens, hrsones, mintens, minones, sectens, secones;
    int checks = 0, errors = 0;
    int t = 0, pre = 0;
    clock #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .switch(switch), .mode(mode),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .hrstens(hrstens), .hrsones(hrsones), .mintens(mintens),
        .minones(minones), .sectens(sectens), .secones(secones)
    );
    always #5 clk = ~clk;
    function automatic logic [35:0] digits(int ts);
        int h, m, s;
        h = ts / 3600;
        m = (ts / 60) % 60;
        s = ts % 60;
        return {6'(h / 10), 6'(h % 10), 6'(m / 10), 6'(m % 10), 6'(s / 10), 6'(s % 10)};
    endfunction
    function automatic int lim(int v, int mx);
        return v > mx ? mx : v;
    endfunction
    task automatic model_edge();
        if (rst) begin
            t = 0;
            pre = 0;
        end else if (mode >= 1 && mode <= 3) begin
            t = lim(hours, 23) * 3600 + lim(minutes, 59) * 60 + lim(seconds, 59);
            pre = 0;
        end else if (mode == 0 && switch) begin
            if (pre == TD - 1) begin
                pre = 0;
                t = (t + 1) % 86400;
            end else
                pre++;
        end
    endtask
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
        end
        #1;
    endtask
    task automatic check(string name, int ts);
        logic [35:0] got, exp;
        got = {hrstens, hrsones, mintens, minones, sectens, secones};
        exp = digits(ts);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (time %0d s)", name, got, exp, ts);
        end
    endtask
    typedef struct {
        logic [2:0] mode;
        logic       sw;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        int         n;
        int         exp;
    } vec_t;
    vec_t vt[15];
    initial begin
        vt[0]  = '{3'd1, 1'b0, 5'd30, 6'd61, 6'd45, 1, 86385};
        vt[1]  = '{3'd2, 1'b1, 5'd23, 6'd59, 6'd59, 1, 86399};
        vt[2]  = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  4, 0};
        vt[3]  = '{3'd3, 1'b0, 5'd9,  6'd59, 6'd58, 1, 35998};
        vt[4]  = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  8, 36000};
        vt[5]  = '{3'd5, 1'b1, 5'd0,  6'd0,  6'd0,  20, 36000};
        vt[6]  = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  2, 36000};
        vt[7]  = '{3'd0, 1'b0, 5'd0,  6'd0,  6'd0,  10, 36000};
        vt[8]  = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  1, 36000};
        vt[9]  = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  1, 36001};
        vt[10] = '{3'd7, 1'b1, 5'd0,  6'd0,  6'd0,  5, 36001};
        vt[11] = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  2, 36001};
        vt[12] = '{3'd2, 1'b0, 5'd5,  6'd6,  6'd7,  1, 18367};
        vt[13] = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  3, 18367};
        vt[14] = '{3'd0, 1'b1, 5'd0,  6'd0,  6'd0,  1, 18368};
        #1;
        check("reset_held", 0);
        step(2);
        rst = 0;
        step(1);
        check("reset_released_idle", 0);
        for (int i = 0; i < 15; i++) begin
            mode = vt[i].mode;
            switch = vt[i].sw;
            hours = vt[i].h;
            minutes = vt[i].m;
            seconds = vt[i].s;
            step(vt[i].n);
            check($sformatf("vec%0d", i), vt[i].exp);
        end
        mode = 1;
        hours = 12;
        minutes = 34;
        seconds = 56;
        step(1);
        check("load_123456", 12 * 3600 + 34 * 60 + 56);
        mode = 0;
        switch = 1;
        step(2);
        #2;
        rst = 1;
        t = 0;
        pre = 0;
        #1;
        check("async_reset_immediate", 0);
        rst = 0;
        step(3);
        check("after_reset_3_edges", 0);
        step(1);
        check("after_reset_4_edges", 1);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            mode = r < 6 ? 3'd0 : r == 6 ? 3'($urandom_range(1, 3)) : r == 7 ? 3'($urandom_range(4, 7)) : 3'd0;
            switch = $urandom_range(0, 4) != 0;
            hours = 5'($urandom);
            minutes = 6'($urandom);
            seconds = 6'($urandom);
            step(1);
            check("random", t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
